// File: rtl/param_fifo.sv
// Parameterised synchronous FIFO with registered read data, occupancy
// flags and sticky overflow/underflow error flags.
//
// Pointers carry one extra wrap bit so that occupancy is simply the
// modular difference of the two pointers; full and empty never alias.
module param_fifo #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int AF_LEVEL = (1 << ADDR_W) - 4,
  parameter int AE_LEVEL = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_i,
  input  logic              write_en,
  input  logic              read_en,
  input  logic              clr_err,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ZERO_C  = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0] ONE_C   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_LEVEL);

  // Storage is deliberately left unreset; reads are only ever issued
  // against entries that have been written.
  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W:0]   wptr_q, wptr_d;
  logic [ADDR_W:0]   rptr_q, rptr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;

  logic              wr_acc_s;
  logic              rd_acc_s;
  logic              mem_we_s;
  logic [ADDR_W:0]   count_s;

  // Occupancy and flags come only from the registered pointers.
  assign count_s      = wptr_q - rptr_q;
  assign full         = (count_s == DEPTH_C);
  assign empty        = (count_s == ZERO_C);
  assign almost_full  = (count_s >= AF_C);
  assign almost_empty = (count_s <= AE_C);
  assign count        = count_s;

  // Acceptance uses start-of-cycle full/empty: no bypass in either direction.
  assign wr_acc_s = write_en & ~full;
  assign rd_acc_s = read_en  & ~empty;
  assign mem_we_s = wr_acc_s & ~rst;

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign overflow  = ovf_q;
  assign underflow = udf_q;

  // Next-state computation for pointers, read data and error flags.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ovf_d   = ovf_q;
    udf_d   = udf_q;

    if (wr_acc_s) begin
      wptr_d = wptr_q + ONE_C;
    end else begin
      wptr_d = wptr_q;
    end

    if (rd_acc_s) begin
      rptr_d  = rptr_q + ONE_C;
      data_d  = mem[rptr_q[ADDR_W-1:0]];
      valid_d = 1'b1;
    end else begin
      rptr_d  = rptr_q;
      data_d  = data_q;
      valid_d = 1'b0;
    end

    // A new error event in the same cycle as clr_err leaves the flag set.
    if (write_en && full) begin
      ovf_d = 1'b1;
    end else if (clr_err) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end

    if (read_en && empty) begin
      udf_d = 1'b1;
    end else if (clr_err) begin
      udf_d = 1'b0;
    end else begin
      udf_d = udf_q;
    end
  end

  // State registers; reset overrides every request in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= ZERO_C;
      rptr_q  <= ZERO_C;
      data_q  <= {DATA_W{1'b0}};
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Memory write port, addressed by the low pointer bits.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem[wptr_q[ADDR_W-1:0]] <= data_i;
    end
  end

endmodule

// File: tb/tb_param_fifo.sv
// Self-checking bench for param_fifo (default parameters): a queue-based
// reference model is compared against every DUT output each cycle, with
// directed literal checks pinning the key scenarios.
module tb_param_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] data_i = 32'd0;
  logic        write_en = 1'b0;
  logic        read_en = 1'b0;
  logic        clr_err = 1'b0;
  logic [31:0] data_o;
  logic        valid_o, full, empty, almost_full, almost_empty;
  logic [5:0]  count;
  logic        overflow, underflow;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  param_fifo dut (
    .clk(clk), .rst(rst), .data_i(data_i), .write_en(write_en),
    .read_en(read_en), .clr_err(clr_err), .data_o(data_o),
    .valid_o(valid_o), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Reference model: plain queue plus sticky flags.
  logic [31:0] m_q [$];
  logic [31:0] m_data = 32'd0;
  bit          m_valid = 1'b0;
  bit          m_ovf = 1'b0;
  bit          m_udf = 1'b0;
  int          rd_cnt = 0;

  always @(posedge clk) begin
    bit full0, empty0;
    if (rst) begin
      m_q.delete();
      m_data  = 32'd0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
      rd_cnt  = 0;
    end else begin
      full0  = (m_q.size() == 32);
      empty0 = (m_q.size() == 0);
      if (read_en && !empty0) begin
        m_data  = m_q.pop_front();
        m_valid = 1'b1;
        rd_cnt++;
      end else begin
        m_valid = 1'b0;
      end
      if (write_en && !full0) m_q.push_back(data_i);
      if (write_en && full0) m_ovf = 1'b1;
      else if (clr_err) m_ovf = 1'b0;
      if (read_en && empty0) m_udf = 1'b1;
      else if (clr_err) m_udf = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("count",        32'(count),        32'(m_q.size()));
      chk("full",         32'(full),         32'(m_q.size() == 32));
      chk("empty",        32'(empty),        32'(m_q.size() == 0));
      chk("almost_full",  32'(almost_full),  32'(m_q.size() >= 28));
      chk("almost_empty", 32'(almost_empty), 32'(m_q.size() <= 4));
      chk("valid_o",      32'(valid_o),      32'(m_valid));
      chk("data_o",       data_o,            m_data);
      chk("overflow",     32'(overflow),     32'(m_ovf));
      chk("underflow",    32'(underflow),    32'(m_udf));
    end
  end

  // Apply one cycle of inputs (entered and left at a falling edge).
  task automatic cyc(input bit we, input bit re, input bit ce, input bit rs,
                     input logic [31:0] d);
    write_en = we; read_en = re; clr_err = ce; rst = rs; data_i = d;
    @(negedge clk);
  endtask

  initial begin
    int w_sent;
    int n;
    @(negedge clk);

    // Reset state
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF);
    chk_en = 1'b1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ae", 32'(almost_empty), 32'd1);
    chk("rst_data", data_o, 32'd0);
    chk("rst_flags", {29'd0, valid_o, overflow, underflow}, 32'd0);

    // Fill 0..31, almost_full after the 28th write
    for (int i = 0; i < 32; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'(i));
      if (i == 26) chk("af_27", 32'(almost_full), 32'd0);
      if (i == 27) chk("af_28", 32'(almost_full), 32'd1);
    end
    chk("fill_count", 32'(count), 32'd32);
    chk("fill_full", 32'(full), 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'hBAD0_0000);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd32);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    chk("ovf_clr", 32'(overflow), 32'd0);

    // Drain, in order, then underflow
    for (int i = 0; i < 32; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
      chk("drain_data", data_o, 32'(i));
      chk("drain_valid", 32'(valid_o), 32'd1);
    end
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    chk("udf_valid", 32'(valid_o), 32'd0);
    chk("udf_set", 32'(underflow), 32'd1);
    chk("udf_hold", data_o, 32'd31);
    // clr_err together with a new underflow: set wins
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    chk("udf_setwins", 32'(underflow), 32'd1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    chk("udf_clr", 32'(underflow), 32'd0);

    // Empty with read+write: write wins, read rejected
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_00E0);
    chk("ew_count", 32'(count), 32'd1);
    chk("ew_valid", 32'(valid_o), 32'd0);
    chk("ew_udf", 32'(underflow), 32'd1);

    // Simultaneous read/write at count 5
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'd0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'(100 + i));
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'(200 + i));
      chk("rw5_count", 32'(count), 32'd5);
      if (i < 5) chk("rw5_data", data_o, 32'(100 + i));
      else       chk("rw5_data", data_o, 32'(200 + i - 5));
    end
    for (int i = 0; i < 27; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'(300 + i));
    chk("rwf_full", 32'(full), 32'd1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'hBAD0_0001);
    chk("rwf_count", 32'(count), 32'd31);
    chk("rwf_ovf", 32'(overflow), 32'd1);
    chk("rwf_data", data_o, 32'd205);

    // Random streaming of 100 words across several wraps
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'd0);
    w_sent = 0;
    n = 0;
    while ((w_sent < 100 || m_q.size() != 0) && n < 3000) begin
      bit we, re;
      we = (w_sent < 100) && ($urandom_range(0, 99) < 55);
      re = ($urandom_range(0, 99) < 50);
      if (we && m_q.size() < 32) begin
        cyc(we, re, 1'b0, 1'b0, 32'(1000 + w_sent));
        w_sent++;
      end else begin
        cyc(we, re, 1'b0, 1'b0, 32'(1000 + w_sent));
      end
      n++;
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("rand_reads", 32'(rd_cnt), 32'd100);
    chk("rand_empty", 32'(empty), 32'd1);

    // Reset while busy, then fresh write/read
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'(500 + i));
    chk("pre_rst_count", 32'(count), 32'd10);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0BAD);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_empty", 32'(empty), 32'd1);
    chk("mid_rst_valid", 32'(valid_o), 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'hABCD_0123);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    chk("post_rst_data", data_o, 32'hABCD_0123);
    chk("post_rst_valid", 32'(valid_o), 32'd1);

    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
